// File: rtl/ic74hc153_mux.sv
// Dual 4-to-1 multiplexer (74HC153 function) with combinational and optionally registered output.
// Optional redundant cross-check of the select path: define IC74HC153_CROSSCHECK_EN.
module ic74hc153_mux #(
   parameter int REG_OUT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [1:0] a,
   input  logic [1:0] s,
   output logic [1:0] y_comb,
   output logic [1:0] y,
   output logic       mismatch_err
);

   // One channel of the part: strobe-gated sum-of-products over the shared select.
   function automatic logic sop_channel(input logic [3:0] i, input logic [1:0] sel, input logic e_n);
      logic s1;
      logic s0;
      s1 = sel[1];
      s0 = sel[0];
      return ~e_n & ((~s1 & ~s0 & i[0]) |
                     (~s1 &  s0 & i[1]) |
                     ( s1 & ~s0 & i[2]) |
                     ( s1 &  s0 & i[3]));
   endfunction

   logic [1:0] gate_y_s;

   // Primary gate-level select path for both channels.
   always_comb begin
      gate_y_s    = 2'b00;
      gate_y_s[0] = sop_channel(d1, a, s[0]);
      gate_y_s[1] = sop_channel(d2, a, s[1]);
   end

   assign y_comb = gate_y_s;

   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic [1:0] y_r;

         // Output register: captures the combinational result every edge.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               y_r <= 2'b00;
            end else begin
               y_r <= gate_y_s;
            end
         end

         assign y = y_r;
      end else begin : g_comb_out
         assign y = gate_y_s;
      end
   endgenerate

`ifdef IC74HC153_CROSSCHECK_EN
   logic [1:0] case_raw_s;
   logic [1:0] case_y_s;
   logic [1:0] idx_y_s;
   logic       mismatch_s;
   logic       mismatch_err_r;

   // Redundant formulation (a): explicit case on the select, strobe applied afterwards.
   always_comb begin
      case_raw_s = 2'b00;
      case (a)
         2'd0:    case_raw_s = {d2[0], d1[0]};
         2'd1:    case_raw_s = {d2[1], d1[1]};
         2'd2:    case_raw_s = {d2[2], d1[2]};
         2'd3:    case_raw_s = {d2[3], d1[3]};
         default: case_raw_s = 2'b00;
      endcase
      case_y_s = case_raw_s & ~s;
   end

   // Redundant formulation (b): indexed bit-select, strobe applied afterwards.
   always_comb begin
      idx_y_s = 2'b00;
      idx_y_s = {d2[a], d1[a]} & ~s;
   end

   // Any disagreement with the primary path is a fault.
   always_comb begin
      mismatch_s = 1'b0;
      if ((case_y_s != gate_y_s) || (idx_y_s != gate_y_s)) begin
         mismatch_s = 1'b1;
      end else begin
         mismatch_s = 1'b0;
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch_err_r <= 1'b0;
      end else if (mismatch_s) begin
         mismatch_err_r <= 1'b1;
      end else begin
         mismatch_err_r <= mismatch_err_r;
      end
   end

   assign mismatch_err = mismatch_err_r;
`else
   assign mismatch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ic74hc153_mux.sv
// Directed self-checking bench for ic74hc153_mux (default REG_OUT=1).
module tb_ic74hc153_mux;

   logic       clk;
   logic       rst_n;
   logic [3:0] d1;
   logic [3:0] d2;
   logic [1:0] a;
   logic [1:0] s;
   logic [1:0] y_comb;
   logic [1:0] y;
   logic       mismatch_err;

   int n_compared = 0;
   int n_mismatched = 0;

   ic74hc153_mux #(.REG_OUT(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .d1           (d1),
      .d2           (d2),
      .a            (a),
      .s            (s),
      .y_comb       (y_comb),
      .y            (y),
      .mismatch_err (mismatch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_compared = n_compared + 1;
      if (obs !== exp) begin
         n_mismatched = n_mismatched + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] golden(input logic [3:0] g1, input logic [3:0] g2,
                                         input logic [1:0] ga, input logic [1:0] gs);
      return {~gs[1] & g2[ga], ~gs[0] & g1[ga]};
   endfunction

   task automatic drive(input logic [3:0] v1, input logic [3:0] v2,
                        input logic [1:0] va, input logic [1:0] vs);
      d1 = v1;
      d2 = v2;
      a  = va;
      s  = vs;
   endtask

   logic [1:0] exp_prev;

   initial begin
      rst_n = 1'b0;
      drive(4'h0, 4'h0, 2'd0, 2'b00);
      #1;
      check_val("rst_y",     {6'd0, y},       8'h00);
      check_val("rst_err",   {7'd0, mismatch_err}, 8'h00);
      check_val("rst_ycomb", {6'd0, y_comb},  8'h00);

      @(negedge clk);
      rst_n = 1'b1;

      // select sweep with both channels enabled
      drive(4'b1010, 4'b0101, 2'd0, 2'b00); #1; check_val("sweep_a0", {6'd0, y_comb}, 8'h02);
      drive(4'b1010, 4'b0101, 2'd1, 2'b00); #1; check_val("sweep_a1", {6'd0, y_comb}, 8'h01);
      drive(4'b1010, 4'b0101, 2'd2, 2'b00); #1; check_val("sweep_a2", {6'd0, y_comb}, 8'h02);
      drive(4'b1010, 4'b0101, 2'd3, 2'b00); #1; check_val("sweep_a3", {6'd0, y_comb}, 8'h01);

      // strobe gating
      drive(4'b1010, 4'b0101, 2'd1, 2'b11); #1; check_val("strobe_11", {6'd0, y_comb}, 8'h00);
      drive(4'b1010, 4'b0101, 2'd1, 2'b10); #1; check_val("strobe_10", {6'd0, y_comb}, 8'h01);
      drive(4'b1010, 4'b0101, 2'd2, 2'b01); #1; check_val("strobe_01", {6'd0, y_comb}, 8'h02);

      // one-cycle latency on y
      @(negedge clk);
      drive(4'b1010, 4'b0101, 2'd0, 2'b00);
      @(posedge clk); #1;
      check_val("lat_a0", {6'd0, y}, 8'h02);
      @(negedge clk);
      drive(4'b1010, 4'b0101, 2'd1, 2'b00);
      #1;
      check_val("lat_hold", {6'd0, y}, 8'h02);
      @(posedge clk); #1;
      check_val("lat_a1", {6'd0, y}, 8'h01);

      // asynchronous reset between edges
      @(negedge clk);
      drive(4'hF, 4'hF, 2'd2, 2'b00);
      @(posedge clk); #1;
      check_val("pre_rst_y", {6'd0, y}, 8'h03);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("async_rst_y",     {6'd0, y},      8'h00);
      check_val("async_rst_ycomb", {6'd0, y_comb}, 8'h03);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("post_rel_hold", {6'd0, y}, 8'h00);
      @(posedge clk); #1;
      check_val("post_rel_cap", {6'd0, y}, 8'h03);

      // exhaustive sweep, one combination per cycle
      exp_prev = 2'b11;
      for (int i = 0; i < 4096; i++) begin
         logic [11:0] v;
         @(negedge clk);
         v = 12'(i);
         drive(v[11:8], v[7:4], v[3:2], v[1:0]);
         #1;
         check_val("exh_ycomb", {6'd0, y_comb}, {6'd0, golden(v[11:8], v[7:4], v[3:2], v[1:0])});
         check_val("exh_y_prev", {6'd0, y}, {6'd0, exp_prev});
         exp_prev = golden(v[11:8], v[7:4], v[3:2], v[1:0]);
         @(posedge clk); #1;
         check_val("exh_y", {6'd0, y}, {6'd0, exp_prev});
      end
      check_val("exh_err", {7'd0, mismatch_err}, 8'h00);

`ifdef IC74HC153_CROSSCHECK_EN
      // fault in a redundant path sets a sticky error
      @(negedge clk);
      drive(4'h0, 4'h0, 2'd0, 2'b11);
      force dut.idx_y_s = 2'b11;
      @(posedge clk); #1;
      check_val("xchk_set", {7'd0, mismatch_err}, 8'h01);
      @(negedge clk);
      release dut.idx_y_s;
      @(posedge clk); #1;
      check_val("xchk_hold", {7'd0, mismatch_err}, 8'h01);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("xchk_clr", {7'd0, mismatch_err}, 8'h00);
      rst_n = 1'b1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
